mem_lsu: RTL and testbench

- Memory-access stage of the RISC-V pipeline, between the EX/MEM boundary and the memory-writeback stage.
- Executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against a variable-latency data-memory port.
- Passes non-memory results straight through.
- Produces one registered writeback record per accepted instruction and stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_lsu.sv | 147 ++++++++++++++
 tb/tb_mem_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-access stage: runs RV32I loads/stores against a variable-latency data port,
// passes ALU results through, and emits one registered writeback record per instruction.
module mem_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_alu,
   input  logic [XLEN-1:0]   in_sdata,
   input  logic [4:0]        in_rd,
   input  logic              in_reg_write,
   input  logic              flush,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_ack,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              out_valid,
   output logic [4:0]        out_rd,
   output logic              out_reg_write,
   output logic [XLEN-1:0]   out_wdata,
   output logic              out_misalign
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [4:0]  rd_q;
   logic        rw_q;

   logic            is_mem, is_st, bad_f3, misal, accept, rw_d;
   logic [XLEN-1:0] st_wdata, ld_shift, ld_data;
   logic [3:0]      st_wstrb;

   // A load wins when both load and store are flagged.
   assign is_mem = in_load | in_store;
   assign is_st  = in_store & ~in_load;
   assign bad_f3 = in_load ? (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7)
                           : (in_funct3[2] || in_funct3 == 3'd3);
   assign misal  = is_mem & (bad_f3
                   | (in_funct3[1:0] == 2'd1 && in_addr[0])
                   | (in_funct3[1:0] == 2'd2 && in_addr[1:0] != 2'b00));
   assign accept = (state_q == IDLE) & in_valid & ~flush;
   assign stall  = (state_q == BUSY) | (accept & is_mem & ~misal);
   assign rw_d   = in_reg_write & (in_rd != 5'd0);

   always_comb begin
      st_wdata = in_sdata;
      st_wstrb = 4'b1111;
      case (in_funct3[1:0])
         2'd0: begin
            st_wdata = {4{in_sdata[7:0]}};
            st_wstrb = 4'b0001 << in_addr[1:0];
         end
         2'd1: begin
            st_wdata = {2{in_sdata[15:0]}};
            st_wstrb = 4'b0011 << in_addr[1:0];
         end
         default: ;
      endcase
   end

   assign ld_shift = dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd4:    ld_data = {24'd0, ld_shift[7:0]};
         3'd5:    ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         f3_q          <= '0;
         off_q         <= '0;
         rd_q          <= '0;
         rw_q          <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_wstrb    <= '0;
         out_valid     <= 1'b0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_wdata     <= '0;
         out_misalign  <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         out_misalign <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               if (!is_mem) begin
                  out_valid     <= 1'b1;
                  out_wdata     <= in_alu;
                  out_rd        <= in_rd;
                  out_reg_write <= rw_d;
               end else if (misal) begin
                  out_valid     <= 1'b1;
                  out_misalign  <= 1'b1;
                  out_wdata     <= '0;
                  out_rd        <= in_rd;
                  out_reg_write <= 1'b0;
               end else begin
                  state_q    <= BUSY;
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_st;
                  dmem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                  dmem_wdata <= is_st ? st_wdata : '0;
                  dmem_wstrb <= is_st ? st_wstrb : 4'b0000;
                  f3_q       <= in_funct3;
                  off_q      <= in_addr[1:0];
                  rd_q       <= in_rd;
                  rw_q       <= rw_d;
               end
            end
            BUSY: if (dmem_ack) begin
               state_q       <= IDLE;
               dmem_req      <= 1'b0;
               dmem_we       <= 1'b0;
               dmem_wstrb    <= 4'b0000;
               out_valid     <= 1'b1;
               out_rd        <= rd_q;
               out_reg_write <= rw_q & ~dmem_we;
               out_wdata     <= dmem_we ? '0 : ld_data;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: the bench plays the data memory and checks every
// record against a behavioural model of the RV32I load/store rules.
module tb_mem_lsu;
   logic        clk = 1'b0, rst;
   logic        in_valid, in_load, in_store, in_reg_write, flush;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_alu, in_sdata;
   logic [4:0]  in_rd;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        out_valid, out_reg_write, out_misalign;
   logic [4:0]  out_rd;
   logic [31:0] out_wdata;

   int         n_chk = 0, n_err = 0;
   logic [4:0] last_rd;

   mem_lsu #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_alu(in_alu), .in_sdata(in_sdata),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_wdata(out_wdata), .out_misalign(out_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int m_size(input bit [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_misal(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] a);
      bit ok;
      if (!(ld || st)) return 1'b0;
      ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
      if (!ok) return 1'b1;
      return (a % m_size(f3)) != 0;
   endfunction

   function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
      longint sz, v;
      sz = m_size(f3);
      if (sz == 4) return rd;
      v = (longint'(rd) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
      if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      return v[31:0];
   endfunction

   function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] sd);
      case (m_size(f3))
         1:       return (sd % 256) * 32'h0101_0101;
         2:       return (sd % 65536) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic bit [3:0] m_strb(input bit [2:0] f3, input bit [31:0] a);
      int m;
      m = ((1 << m_size(f3)) - 1) << (a % 4);
      return m[3:0];
   endfunction

   // One instruction from presentation to completion, followed by one idle cycle.
   task automatic do_instr(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] a,
                           input bit [31:0] alu, input bit [31:0] sd, input bit [4:0] rd,
                           input bit rw, input bit fl, input int dly, input bit [31:0] rdata);
      bit mem, mis, wr, busy;
      mem  = ld || st;
      mis  = m_misal(ld, st, f3, a);
      wr   = st && !ld;
      busy = !fl && mem && !mis;
      @(negedge clk);
      in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = a;
      in_alu = alu; in_sdata = sd; in_rd = rd; in_reg_write = rw; flush = fl;
      #1 check("stall_accept", stall, busy);
      @(posedge clk); #1;
      in_valid = 0; flush = 0;
      if (fl) begin
         check("flush_valid", out_valid, 0);
         check("flush_rd_hold", out_rd, last_rd);
         check("flush_req", dmem_req, 0);
      end else if (!mem) begin
         check("pt_valid", out_valid, 1);
         check("pt_misalign", out_misalign, 0);
         check("pt_wdata", out_wdata, alu);
         check("pt_rd", out_rd, rd);
         check("pt_regwr", out_reg_write, rw && rd != 0);
         check("pt_stall", stall, 0);
         last_rd = rd;
      end else if (mis) begin
         check("mis_valid", out_valid, 1);
         check("mis_flag", out_misalign, 1);
         check("mis_regwr", out_reg_write, 0);
         check("mis_rd", out_rd, rd);
         check("mis_req", dmem_req, 0);
         check("mis_stall", stall, 0);
         last_rd = rd;
      end else begin
         check("req", dmem_req, 1);
         check("we", dmem_we, wr);
         check("addr", dmem_addr, a & 32'hFFFF_FFFC);
         check("wstrb", dmem_wstrb, wr ? m_strb(f3, a) : 4'b0000);
         if (wr) check("wdata", dmem_wdata, m_wdata(f3, sd));
         check("busy_valid", out_valid, 0);
         check("busy_stall", stall, 1);
         for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            check("wait_req", dmem_req, 1);
            check("wait_addr", dmem_addr, a & 32'hFFFF_FFFC);
            check("wait_valid", out_valid, 0);
            check("wait_stall", stall, 1);
         end
         @(negedge clk);
         dmem_ack = 1; dmem_rdata = rdata;
         @(posedge clk); #1;
         dmem_ack = 0; dmem_rdata = $urandom;
         check("done_valid", out_valid, 1);
         check("done_misalign", out_misalign, 0);
         check("done_rd", out_rd, rd);
         check("done_regwr", out_reg_write, !wr && rw && rd != 0);
         check("done_wdata", out_wdata, wr ? 32'd0 : m_load(f3, a, rdata));
         check("done_req", dmem_req, 0);
         check("done_stall", stall, 0);
         last_rd = rd;
      end
      @(posedge clk); #1;
      check("idle_valid", out_valid, 0);
      check("idle_misalign", out_misalign, 0);
      check("idle_rd_hold", out_rd, last_rd);
   endtask

   initial begin
      rst = 1; in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0; in_addr = 0;
      in_alu = 0; in_sdata = 0; in_rd = 0; in_reg_write = 0; flush = 0;
      dmem_ack = 0; dmem_rdata = 0; last_rd = 0;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall, 0);
      check("rst_wdata", out_wdata, 0);
      check("rst_wstrb", dmem_wstrb, 0);
      @(negedge clk); rst = 0;

      do_instr(0, 0, 3'd0, 32'h0,     32'h0000_1234, 32'h0,     5'd5, 1, 0, 0, 32'h0);
      do_instr(1, 0, 3'd0, 32'h103,   32'h0,         32'h0,     5'd6, 1, 0, 0, 32'h80FF_0000);
      do_instr(1, 0, 3'd5, 32'h202,   32'h0,         32'h0,     5'd7, 1, 0, 2, 32'hBEEF_1234);
      do_instr(0, 1, 3'd0, 32'h301,   32'h0,         32'h0000_00AA, 5'd8, 1, 0, 1, 32'h0);
      do_instr(1, 0, 3'd2, 32'h402,   32'h0,         32'h0,     5'd9, 1, 0, 0, 32'h0);
      do_instr(1, 0, 3'd1, 32'h602,   32'h0,         32'h0,     5'd0, 1, 0, 0, 32'h8001_0000);
      do_instr(1, 1, 3'd2, 32'h700,   32'h0,         32'hDEAD_BEEF, 5'd3, 1, 0, 0, 32'h1357_9BDF);
      do_instr(0, 1, 3'd1, 32'h802,   32'h0,         32'h1234_5678, 5'd4, 1, 0, 0, 32'h0);
      do_instr(0, 0, 3'd0, 32'h0,     32'hCAFE_0000, 32'h0,     5'd10, 1, 1, 0, 32'h0);

      // Reset while a load is outstanding; the late ack must be ignored.
      @(negedge clk);
      in_valid = 1; in_load = 1; in_store = 0; in_funct3 = 3'd2; in_addr = 32'h500;
      in_rd = 5'd11; in_reg_write = 1; flush = 0;
      @(posedge clk); #1 in_valid = 0;
      check("rb_req", dmem_req, 1);
      @(negedge clk); rst = 1;
      #1;
      check("rb_req_drop", dmem_req, 0);
      check("rb_stall", stall, 0);
      check("rb_valid", out_valid, 0);
      @(negedge clk); rst = 0; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
      @(posedge clk); #1 dmem_ack = 0;
      check("rb_late_ack", out_valid, 0);
      check("rb_req_after", dmem_req, 0);
      last_rd = 0;
      do_instr(0, 0, 3'd0, 32'h0, 32'h0000_4321, 32'h0, 5'd12, 1, 0, 0, 32'h0);

      for (int k = 0; k < 300; k++) begin
         int kind;
         kind = $urandom_range(0, 9);
         do_instr(kind >= 3 && kind <= 6, kind >= 6, 3'($urandom_range(0, 7)), $urandom,
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
